// File: rtl/aes_shift_mix_seq.sv
// aes_shift_mix_seq: encrypt-direction round middle (ShiftRows then MixColumns)
// on a 128-bit AES state. ShiftRows is applied when the state is accepted.
// MixColumns then runs COLS_PER_CYCLE columns per clock, in place.
// Optional feature macro: AES_FINAL_ROUND_EN adds a final_round input that
// skips MixColumns for the last cipher round.
module aes_shift_mix_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef AES_FINAL_ROUND_EN
  input  logic         final_round,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_shift_mix_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

  state_t         state;
  logic [1:0]     col;
  logic [127:0]   st_reg;
  logic [127:0]   mixed;
  logic           last;
  logic           skip_mix;

  // GF(2^8) multiply by 2 with the AES reduction polynomial
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; row 0 sits in the most significant byte
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] o0, o1, o2, o3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    o0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    o1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    o2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    o3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    return {o0, o1, o2, o3};
  endfunction

  // Row r rotates left by r: s'[r][c] = s[r][(c+r)%4]
  function automatic logic [127:0] shift_rows(input logic [127:0] d);
    logic [127:0] s;
    s = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        s[127-8*(4*c+r) -: 8] = d[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return s;
  endfunction

`ifdef AES_FINAL_ROUND_EN
  assign skip_mix = final_round;
`else
  assign skip_mix = 1'b0;
`endif

  // Replace the columns in the current window with their MixColumns result
  always_comb begin
    mixed = st_reg;
    for (int c = 0; c < 4; c++) begin
      if (c >= int'(col) && c < int'(col) + COLS_PER_CYCLE) begin
        mixed[127-32*c -: 32] = mix_col(st_reg[127-32*c -: 32]);
      end
    end
  end

  // The window that reaches column 3 finishes the state
  assign last = (int'(col) + COLS_PER_CYCLE) >= 4;

  // Control FSM plus state register; reset discards any partial state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      col    <= 2'd0;
      st_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st_reg <= shift_rows(in_data);
            col    <= 2'd0;
            state  <= skip_mix ? DONE : MIX;
          end
        end
        MIX: begin
          st_reg <= mixed;
          col    <= last ? 2'd0 : col + 2'(COLS_PER_CYCLE);
          if (last) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = st_reg;

endmodule

// File: tb/tb_aes_shift_mix_seq.sv
// Directed bench for aes_shift_mix_seq: three instances (1, 2 and 4 columns
// per clock) share the same input stimulus.
module tb_aes_shift_mix_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         final_round;

  logic         ir1, ov1, bz1;
  logic [127:0] od1;
  logic         ir2, ov2, bz2;
  logic [127:0] od2;
  logic         ir4, ov4, bz4;
  logic [127:0] od4;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] V  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] E  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] C  = {4{32'hdb135345}};
  localparam logic [127:0] EC = {4{32'h8e4da1bc}};
  localparam logic [127:0] SR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  always #5 clk = ~clk;

  aes_shift_mix_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
`ifdef AES_FINAL_ROUND_EN
    .final_round(final_round),
`endif
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bz1));

  aes_shift_mix_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
`ifdef AES_FINAL_ROUND_EN
    .final_round(final_round),
`endif
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .busy(bz2));

  aes_shift_mix_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
`ifdef AES_FINAL_ROUND_EN
    .final_round(final_round),
`endif
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(bz4));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic prev;

    rst_n = 1'b0; in_valid = 1'b1; in_data = V; out_ready = 1'b0; final_round = 1'b0;

    // Reset state, with in_valid held high across reset edges
    tick(); tick();
    chk("rst_ov1", ov1, 0);
    chk("rst_od1", od1, 0);
    chk("rst_bz1", bz1, 0);
    chk("rst_od4", od4, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("rel_ir1", ir1, 1);
    chk("rel_bz1", bz1, 0);

    // Accept the FIPS-197 vector on all three instances
    in_valid = 1'b1; in_data = V;
    tick();
    in_valid = 1'b0;
    chk("acc_bz1", bz1, 1);
    chk("acc_ir1", ir1, 0);
    chk("acc_ov4", ov4, 0);
    tick();
    chk("n4_ov", ov4, 1);
    chk("n4_od", od4, E);
    chk("n4_ov2", ov2, 0);
    tick();
    chk("n2_ov", ov2, 1);
    chk("n2_od", od2, E);
    chk("n2_ov1", ov1, 0);
    tick();
    chk("n1_ov_3clk", ov1, 0);
    tick();
    chk("n1_ov", ov1, 1);
    chk("n1_od", od1, E);

    // Backpressure for 10 clocks; an in_valid pulse in DONE must be ignored
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin in_valid = 1'b1; in_data = C; end
      else in_valid = 1'b0;
      tick();
      chk("bp_ov1", ov1, 1);
      chk("bp_od1", od1, E);
      chk("bp_ir1", ir1, 0);
    end
    in_valid = 1'b0;
    chk("bp_od4", od4, E);
    out_ready = 1'b1;
    tick();
    chk("hs_ov1", ov1, 0);
    chk("hs_ir1", ir1, 1);
    out_ready = 1'b0;
    tick();
    chk("hs_bz1", bz1, 0);
    chk("hs_od1", od1, E);

    // Asynchronous reset while dut1 is at column 2
    in_valid = 1'b1; in_data = V;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov1", ov1, 0);
    chk("ar_od1", od1, 0);
    chk("ar_bz1", bz1, 0);
    chk("ar_ov4", ov4, 0);
    chk("ar_od4", od4, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("ar_ir1", ir1, 1);
    in_valid = 1'b1; in_data = C;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("ar_next_ov1_early", ov1, 0);
    tick();
    chk("ar_next_ov1", ov1, 1);
    chk("ar_next_od1", od1, EC);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ar_next_ir1", ir1, 1);

    // Back-to-back, in_valid and out_ready held high
    in_valid = 1'b1; in_data = C; out_ready = 1'b1;
    cnt = 0; prev = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (ov1) begin
        chk("b2b_od1", od1, EC);
        cnt++;
      end
      if (prev) begin
        chk("b2b_ov1_fall", ov1, 0);
        chk("b2b_ir1_rise", ir1, 1);
      end
      prev = ov1;
    end
    chk("b2b_count", 128'(cnt), 4);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    out_ready = 1'b0;
    chk("b2b_idle", bz1, 0);

`ifdef AES_FINAL_ROUND_EN
    // Final round skips MixColumns
    in_valid = 1'b1; in_data = V; final_round = 1'b1;
    tick();
    in_valid = 1'b0; final_round = 1'b0;
    tick();
    chk("fr_ov1", ov1, 1);
    chk("fr_od1", od1, SR);
    chk("fr_od4", od4, SR);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fr_ir1", ir1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
